// File: rtl/stream_mux_pkg.sv
// Shared encodings for the registered N-to-1 stream multiplexer.
package stream_mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr, wrapping.
module rr_arbiter #(
  parameter int unsigned  NUM_CH = 4,
  localparam int unsigned SEL_W  = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req_i,
  input  logic [SEL_W-1:0]  ptr_i,
  output logic              grant_valid_o,
  output logic [SEL_W-1:0]  grant_o
);

  always_comb begin
    grant_valid_o = 1'b0;
    grant_o       = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (!grant_valid_o && req_i[(32'(ptr_i) + k) % NUM_CH]) begin
        grant_valid_o = 1'b1;
        grant_o       = SEL_W'((32'(ptr_i) + k) % NUM_CH);
      end
    end
  end

endmodule

// File: rtl/stream_mux_rr.sv
// Registered N-to-1 valid/ready stream mux with fixed-select or round-robin channel choice.
module stream_mux_rr
  import stream_mux_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned SEL_W  = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        in_valid,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  output logic [NUM_CH-1:0]        in_ready,
  input  logic                     mode,
  input  logic [SEL_W-1:0]         sel,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic [SEL_W-1:0]         out_ch,
  input  logic                     out_ready
);

  out_state_e        state_q;
  logic [DATA_W-1:0] data_q;
  logic [SEL_W-1:0]  ch_q;
  logic [SEL_W-1:0]  ptr_q, ptr_d;

  logic              rr_valid;
  logic [SEL_W-1:0]  rr_grant;
  logic              fix_valid;
  logic              grant_valid;
  logic [SEL_W-1:0]  grant;
  logic [DATA_W-1:0] grant_data;
  logic              load_en;
  logic              xfer;

  rr_arbiter #(
    .NUM_CH(NUM_CH)
  ) u_arb (
    .req_i        (in_valid),
    .ptr_i        (ptr_q),
    .grant_valid_o(rr_valid),
    .grant_o      (rr_grant)
  );

  assign out_valid = (state_q == ST_FULL);
  assign out_data  = data_q;
  assign out_ch    = ch_q;

  always_comb begin
    // sel values at or above NUM_CH match no channel, so they never grant.
    fix_valid = 1'b0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (32'(sel) == i && in_valid[i]) fix_valid = 1'b1;
    end

    if (mode == MODE_RR) begin
      grant_valid = rr_valid;
      grant       = rr_grant;
    end else begin
      grant_valid = fix_valid;
      grant       = sel;
    end

    load_en = !out_valid || out_ready;
    xfer    = !rst && load_en && grant_valid;

    grant_data = '0;
    in_ready   = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (32'(grant) == i) begin
        grant_data  = in_data[i*DATA_W +: DATA_W];
        in_ready[i] = xfer;
      end
    end

    ptr_d = ptr_q;
    if (xfer && mode == MODE_RR) begin
      ptr_d = (32'(grant) == NUM_CH - 1) ? '0 : grant + SEL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      data_q  <= '0;
      ch_q    <= '0;
      ptr_q   <= '0;
    end else begin
      case (state_q)
        ST_EMPTY: if (xfer) state_q <= ST_FULL;
        ST_FULL:  if (out_ready && !xfer) state_q <= ST_EMPTY;
      endcase
      if (xfer) begin
        data_q <= grant_data;
        ch_q   <= grant;
      end
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: tb/tb_stream_mux_rr.sv
// Self-checking bench for stream_mux_rr: directed vector table, random model run, NUM_CH=3 corners.
module tb_stream_mux_rr;

  localparam int unsigned NCH = 4;
  localparam logic [31:0] D   = 32'hA3A2A1A0;
  localparam logic [31:0] DB  = 32'hA3A25CA0;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  in_valid, in_ready;
  logic [31:0] in_data;
  logic        mode, out_valid, out_ready;
  logic [1:0]  sel, out_ch;
  logic [7:0]  out_data;

  logic [2:0]  c_iv, c_ir;
  logic [23:0] c_id;
  logic        c_mode, c_ov, c_ordy;
  logic [1:0]  c_sel, c_och;
  logic [7:0]  c_od;

  stream_mux_rr #(.NUM_CH(4), .DATA_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .mode(mode), .sel(sel), .out_valid(out_valid), .out_data(out_data), .out_ch(out_ch),
    .out_ready(out_ready)
  );

  stream_mux_rr #(.NUM_CH(3), .DATA_W(8)) dut3 (
    .clk(clk), .rst(rst), .in_valid(c_iv), .in_data(c_id), .in_ready(c_ir),
    .mode(c_mode), .sel(c_sel), .out_valid(c_ov), .out_data(c_od), .out_ch(c_och),
    .out_ready(c_ordy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rst;
    logic        mode;
    logic [1:0]  sel;
    logic [3:0]  iv;
    logic        ordy;
    logic [31:0] data;
    logic        e_ov;
    logic [1:0]  e_ch;
    logic [7:0]  e_dat;
    logic [3:0]  e_ir;
    logic        chk_dat;
  } vec_t;

  vec_t tbl[25];

  typedef struct {
    int         ch;
    logic [7:0] d;
  } beat_t;

  beat_t q[$];
  int    m_ptr;

  // Spec-level grant rule: fixed select, or first valid searching upward from ptr.
  function automatic void ref_grant(input logic md, input int s, input logic [3:0] v,
                                    input int p, output bit gv, output int g);
    gv = 1'b0;
    g  = 0;
    if (md == 1'b0) begin
      if (s < NCH && v[s]) begin
        gv = 1'b1;
        g  = s;
      end
    end else begin
      for (int k = 0; k < NCH; k++) begin
        if (!gv && v[(p + k) % NCH]) begin
          gv = 1'b1;
          g  = (p + k) % NCH;
        end
      end
    end
  endfunction

  initial begin
    bit         gv;
    int         g;
    bit         le;
    logic [3:0] exp_ir;

    //            rst   mode  sel   iv     ordy  data  ov    ch    dat    ir     chk_dat
    tbl[0]  = '{1'b1, 1'b1, 2'd0, 4'hF, 1'b1, D,  1'b0, 2'd0, 8'h00, 4'h0, 1'b1};
    tbl[1]  = '{1'b1, 1'b1, 2'd0, 4'hF, 1'b1, D,  1'b0, 2'd0, 8'h00, 4'h0, 1'b1};
    tbl[2]  = '{1'b0, 1'b1, 2'd0, 4'hF, 1'b1, D,  1'b0, 2'd0, 8'h00, 4'h1, 1'b1};
    tbl[3]  = '{1'b0, 1'b1, 2'd0, 4'hF, 1'b1, D,  1'b1, 2'd0, 8'hA0, 4'h2, 1'b1};
    tbl[4]  = '{1'b0, 1'b1, 2'd0, 4'hF, 1'b1, D,  1'b1, 2'd1, 8'hA1, 4'h4, 1'b1};
    tbl[5]  = '{1'b0, 1'b1, 2'd0, 4'hF, 1'b1, D,  1'b1, 2'd2, 8'hA2, 4'h8, 1'b1};
    tbl[6]  = '{1'b0, 1'b1, 2'd0, 4'hF, 1'b1, D,  1'b1, 2'd3, 8'hA3, 4'h1, 1'b1};
    tbl[7]  = '{1'b0, 1'b1, 2'd0, 4'hF, 1'b1, D,  1'b1, 2'd0, 8'hA0, 4'h2, 1'b1};
    tbl[8]  = '{1'b0, 1'b1, 2'd0, 4'hF, 1'b1, D,  1'b1, 2'd1, 8'hA1, 4'h4, 1'b1};
    tbl[9]  = '{1'b0, 1'b1, 2'd0, 4'h5, 1'b1, D,  1'b1, 2'd2, 8'hA2, 4'h1, 1'b1};
    tbl[10] = '{1'b0, 1'b1, 2'd0, 4'h5, 1'b1, D,  1'b1, 2'd0, 8'hA0, 4'h4, 1'b1};
    tbl[11] = '{1'b0, 1'b1, 2'd0, 4'h5, 1'b1, D,  1'b1, 2'd2, 8'hA2, 4'h1, 1'b1};
    tbl[12] = '{1'b0, 1'b0, 2'd2, 4'hF, 1'b1, D,  1'b1, 2'd0, 8'hA0, 4'h4, 1'b1};
    tbl[13] = '{1'b0, 1'b0, 2'd2, 4'hF, 1'b1, D,  1'b1, 2'd2, 8'hA2, 4'h4, 1'b1};
    tbl[14] = '{1'b0, 1'b0, 2'd1, 4'hD, 1'b1, D,  1'b1, 2'd2, 8'hA2, 4'h0, 1'b1};
    tbl[15] = '{1'b0, 1'b0, 2'd1, 4'hD, 1'b1, D,  1'b0, 2'd0, 8'h00, 4'h0, 1'b0};
    tbl[16] = '{1'b0, 1'b1, 2'd0, 4'hF, 1'b0, DB, 1'b0, 2'd0, 8'h00, 4'h2, 1'b0};
    tbl[17] = '{1'b0, 1'b1, 2'd0, 4'hF, 1'b0, DB, 1'b1, 2'd1, 8'h5C, 4'h0, 1'b1};
    tbl[18] = '{1'b0, 1'b1, 2'd0, 4'hF, 1'b0, DB, 1'b1, 2'd1, 8'h5C, 4'h0, 1'b1};
    tbl[19] = '{1'b0, 1'b1, 2'd0, 4'hF, 1'b0, DB, 1'b1, 2'd1, 8'h5C, 4'h0, 1'b1};
    tbl[20] = '{1'b0, 1'b1, 2'd0, 4'hF, 1'b1, DB, 1'b1, 2'd1, 8'h5C, 4'h4, 1'b1};
    tbl[21] = '{1'b0, 1'b1, 2'd0, 4'hF, 1'b1, D,  1'b1, 2'd2, 8'hA2, 4'h8, 1'b1};
    tbl[22] = '{1'b1, 1'b1, 2'd0, 4'hF, 1'b1, D,  1'b1, 2'd3, 8'hA3, 4'h0, 1'b1};
    tbl[23] = '{1'b0, 1'b1, 2'd0, 4'hF, 1'b1, D,  1'b0, 2'd0, 8'h00, 4'h1, 1'b1};
    tbl[24] = '{1'b0, 1'b1, 2'd0, 4'hF, 1'b1, D,  1'b1, 2'd0, 8'hA0, 4'h2, 1'b1};

    rst = 1'b1; mode = 1'b1; sel = 2'd0; in_valid = 4'hF; in_data = D; out_ready = 1'b1;
    c_mode = 1'b0; c_sel = 2'd0; c_iv = 3'b000; c_id = 24'hC2C1C0; c_ordy = 1'b1;
    @(posedge clk); #1;

    // Directed vectors: outputs sampled mid-cycle, inputs held across the edge.
    for (int r = 0; r < 25; r++) begin
      rst = tbl[r].rst; mode = tbl[r].mode; sel = tbl[r].sel; in_valid = tbl[r].iv;
      out_ready = tbl[r].ordy; in_data = tbl[r].data;
      @(negedge clk);
      chk($sformatf("vec%0d_in_ready", r), 32'(in_ready), 32'(tbl[r].e_ir));
      chk($sformatf("vec%0d_out_valid", r), 32'(out_valid), 32'(tbl[r].e_ov));
      if (tbl[r].chk_dat) begin
        chk($sformatf("vec%0d_out_ch", r), 32'(out_ch), 32'(tbl[r].e_ch));
        chk($sformatf("vec%0d_out_data", r), 32'(out_data), 32'(tbl[r].e_dat));
      end
      @(posedge clk); #1;
    end

    // Random run against the reference model.
    rst = 1'b1;
    @(posedge clk); #1;
    q.delete();
    m_ptr = 0;
    for (int n = 0; n < 3000; n++) begin
      rst       = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 15) == 0) mode = ~mode;
      sel       = 2'($urandom_range(0, 3));
      in_valid  = 4'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      in_data   = $urandom;
      @(negedge clk);
      ref_grant(mode, int'(sel), in_valid, m_ptr, gv, g);
      le     = (q.size() == 0) || out_ready;
      exp_ir = (!rst && le && gv) ? 4'(1 << g) : 4'h0;
      chk("rand_in_ready", 32'(in_ready), 32'(exp_ir));
      chk("rand_out_valid", 32'(out_valid), 32'(q.size() != 0));
      if (q.size() != 0) begin
        chk("rand_out_ch", 32'(out_ch), 32'(q[0].ch));
        chk("rand_out_data", 32'(out_data), 32'(q[0].d));
      end
      @(posedge clk);
      if (rst) begin
        q.delete();
        m_ptr = 0;
      end else begin
        if (q.size() != 0 && out_ready) void'(q.pop_front());
        if (le && gv) begin
          q.push_back('{g, in_data[g*8 +: 8]});
          if (mode) m_ptr = (g + 1) % NCH;
        end
      end
      #1;
    end

    // NUM_CH=3: out-of-range select and pointer wrap from 2 to 0.
    rst = 1'b1; in_valid = 4'h0; c_mode = 1'b0; c_sel = 2'd3; c_iv = 3'b111; c_ordy = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("n3_sel_oob_ready", 32'(c_ir), 32'h0);
    chk("n3_sel_oob_valid", 32'(c_ov), 32'h0);
    @(posedge clk); #1;
    c_sel = 2'd2;
    @(negedge clk);
    chk("n3_sel2_ready", 32'(c_ir), 32'h4);
    chk("n3_sel_oob_still_empty", 32'(c_ov), 32'h0);
    @(posedge clk); #1;
    c_mode = 1'b1;
    for (int s = 0; s < 4; s++) begin
      @(negedge clk);
      chk($sformatf("n3_rr%0d_ready", s), 32'(c_ir), 32'(3'b001 << (s % 3)));
      chk($sformatf("n3_rr%0d_valid", s), 32'(c_ov), 32'h1);
      chk($sformatf("n3_rr%0d_ch", s), 32'(c_och), 32'((s + 2) % 3));
      chk($sformatf("n3_rr%0d_data", s), 32'(c_od), 32'(8'hC0 + 8'((s + 2) % 3)));
      @(posedge clk); #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
